// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Package     : cotm32_pkg
// Description : Core-wide constants shared by the cotm32 fetch/execute blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package cotm32_pkg;
  localparam int XLEN = 32;
endpackage

// ============================================================================
// Module      : branch_predictor
// Description : Bimodal branch predictor with a direct-mapped branch target
//               buffer. Fetch looks up i_pc combinationally. Execute writes
//               back resolved conditional branches, which trains the 2-bit
//               counters and the BTB. The writeback also raises a misprediction
//               flag and updates the hit/miss statistics.
// Revision    : 1.0 - initial release
//
// Ports:
//   i_clk              core clock, rising-edge active
//   i_rst_n            asynchronous active-low reset
//   i_pc               fetch PC to look up
//   o_pred_take        prediction for i_pc is taken
//   o_pred_target      predicted target (0 when not predicted taken)
//   i_upd_valid        a resolved conditional branch is present this cycle
//   i_upd_pc           PC of the resolved branch
//   i_upd_take         actual outcome
//   i_upd_target       actual taken target
//   i_upd_pred_take    prediction carried down the pipe
//   i_upd_pred_target  predicted target carried down the pipe
//   o_mispredict       resolved outcome differs from the carried prediction
//   o_hit_cnt          saturating count of correct predictions
//   o_miss_cnt         saturating count of mispredictions
// ============================================================================
module branch_predictor
  import cotm32_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_pred_take,
  output logic [XLEN-1:0] o_pred_target,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_take,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_upd_pred_take,
  input  logic [XLEN-1:0] i_upd_pred_target,
  output logic            o_mispredict,
  output logic [15:0]     o_hit_cnt,
  output logic [15:0]     o_miss_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [1:0]  c_ctr_strong_nt = 2'b00;
  localparam logic [1:0]  c_ctr_weak_nt   = 2'b01;
  localparam logic [1:0]  c_ctr_weak_t    = 2'b10;
  localparam logic [1:0]  c_ctr_strong_t  = 2'b11;
  localparam logic [15:0] c_cnt_max       = 16'hFFFF;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [XLEN-1:0]    r_tgt [ENTRIES];
  logic [1:0]         r_ctr [ENTRIES];
  logic [15:0]        r_hit_cnt;
  logic [15:0]        r_miss_cnt;

  // --------------------------------------------------------------------------
  // Lookup path (fetch side)
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  logic [1:0]       w_lk_ctr;

  assign w_lk_idx = i_pc[IDX_W+1:2];
  assign w_lk_tag = i_pc[XLEN-1:IDX_W+2];
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_ctr = r_ctr[w_lk_idx];

  // Reads come straight from the storage arrays, so an update landing on the
  // same entry this cycle is only seen on the following cycle.
  assign o_pred_take   = w_lk_hit && w_lk_ctr[1];
  assign o_pred_target = o_pred_take ? r_tgt[w_lk_idx] : '0;

  // --------------------------------------------------------------------------
  // Update path (execute writeback)
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic [1:0]       w_up_ctr;
  logic [1:0]       w_up_ctr_next;
  logic             w_mispredict;

  assign w_up_idx = i_upd_pc[IDX_W+1:2];
  assign w_up_tag = i_upd_pc[XLEN-1:IDX_W+2];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_up_ctr = r_ctr[w_up_idx];

  // Saturating 2-bit counter step.
  always_comb begin
    w_up_ctr_next = w_up_ctr;
    if (i_upd_take) begin
      if (w_up_ctr != c_ctr_strong_t) w_up_ctr_next = w_up_ctr + 2'b01;
    end else begin
      if (w_up_ctr != c_ctr_strong_nt) w_up_ctr_next = w_up_ctr - 2'b01;
    end
  end

  // A taken branch is also wrong when its carried target disagrees; the
  // target of a not-taken branch is irrelevant.
  assign w_mispredict = i_upd_valid &&
                        ((i_upd_take != i_upd_pred_take) ||
                         (i_upd_take && (i_upd_target != i_upd_pred_target)));

  // Held low during reset so every combinational output resolves to zero.
  assign o_mispredict = i_rst_n && w_mispredict;

  // BHT / BTB state. Never-taken branches are not allocated, which keeps the
  // table free for branches that actually redirect fetch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i] <= '0;
        r_tgt[i] <= '0;
        r_ctr[i] <= c_ctr_weak_nt;
      end
    end else if (i_upd_valid) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= w_up_ctr_next;
        if (i_upd_take) r_tgt[w_up_idx] <= i_upd_target;
      end else if (i_upd_take) begin
        // Allocate, evicting whatever branch aliased onto this index.
        r_valid[w_up_idx] <= 1'b1;
        r_tag[w_up_idx]   <= w_up_tag;
        r_tgt[w_up_idx]   <= i_upd_target;
        r_ctr[w_up_idx]   <= c_ctr_weak_t;
      end
    end
  end

  // Statistics, each saturating at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (i_upd_valid) begin
      if (w_mispredict) begin
        if (r_miss_cnt != c_cnt_max) r_miss_cnt <= r_miss_cnt + 16'd1;
      end else begin
        if (r_hit_cnt != c_cnt_max) r_hit_cnt <= r_hit_cnt + 16'd1;
      end
    end
  end

  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;

  // Instruction-alignment bits do not take part in indexing or tagging.
  logic w_unused_pc_lsbs;
  assign w_unused_pc_lsbs = ^{i_pc[1:0], i_upd_pc[1:0]};

endmodule
`default_nettype wire
